mips_alu: RTL and testbench

- Combinational 32-bit MIPS ALU for the single-cycle Harvard CPU, with clocked HI/LO special registers.
- Produces the result for arithmetic, logic, shift, compare and LUI ops, plus the branch-condition flag consumed by control.
- Holds HI/LO for MULT/MULTU/DIV/DIVU/MTHI/MTLO and exposes them for MFHI/MFLO writeback.

---
 rtl/mips_alu.sv | 135 +++++++++++++
 tb/tb_mips_alu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
// 32-bit MIPS ALU: combinational result/branch flag plus clocked HI/LO registers.
// Define MIPS_ALU_DIV_EN to include the DIV/DIVU divider; otherwise ops 17/18 act as reserved.
module mips_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ALUOp,
  input  logic [4:0]  shamt,
  input  logic [31:0] Hi_in,
  input  logic [31:0] Lo_in,
  input  logic        SpcRegWriteEn,
  output logic        ALUCond,
  output logic [31:0] ALURes,
  output logic [31:0] ALUHi,
  output logic [31:0] ALULo
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_AND  = 5'd2,  OP_OR    = 5'd3,
    OP_XOR   = 5'd4,  OP_NOR   = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU  = 5'd7,
    OP_SLL   = 5'd8,  OP_SRL   = 5'd9,  OP_SRA  = 5'd10, OP_SLLV  = 5'd11,
    OP_SRLV  = 5'd12, OP_SRAV  = 5'd13, OP_LUI  = 5'd14, OP_MULT  = 5'd15,
    OP_MULTU = 5'd16, OP_DIV   = 5'd17, OP_DIVU = 5'd18, OP_MTHI  = 5'd19,
    OP_MTLO  = 5'd20, OP_BEQ   = 5'd21, OP_BNE  = 5'd22, OP_BGEZ  = 5'd23,
    OP_BGTZ  = 5'd24, OP_BLEZ  = 5'd25, OP_BLTZ = 5'd26
  } alu_op_e;

  alu_op_e w_op;
  assign w_op = alu_op_e'(ALUOp);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [4:0]  w_var_amt;
  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;
  logic        w_a_neg;
  logic        w_a_zero;

  assign w_var_amt = A[4:0];
  assign w_mul_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_mul_u   = {32'd0, A} * {32'd0, B};
  assign w_a_neg   = A[31];
  assign w_a_zero  = (A == 32'd0);

`ifdef MIPS_ALU_DIV_EN
  logic        w_div_ovf;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;

  // The most-negative / -1 case overflows the signed quotient; pin it explicitly.
  assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_quo_s   = w_div_ovf ? 32'h8000_0000 : 32'($signed(A) / $signed(B));
  assign w_rem_s   = w_div_ovf ? 32'd0         : 32'($signed(A) % $signed(B));
  assign w_quo_u   = A / B;
  assign w_rem_u   = A % B;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    ALURes  = 32'd0;
    ALUCond = 1'b0;
    case (w_op)
      OP_ADD:  ALURes = A + B;
      OP_SUB:  ALURes = A - B;
      OP_AND:  ALURes = A & B;
      OP_OR:   ALURes = A | B;
      OP_XOR:  ALURes = A ^ B;
      OP_NOR:  ALURes = ~(A | B);
      OP_SLT:  ALURes = {31'd0, ($signed(A) < $signed(B))};
      OP_SLTU: ALURes = {31'd0, (A < B)};
      OP_SLL:  ALURes = B << shamt;
      OP_SRL:  ALURes = B >> shamt;
      OP_SRA:  ALURes = $unsigned($signed(B) >>> shamt);
      OP_SLLV: ALURes = B << w_var_amt;
      OP_SRLV: ALURes = B >> w_var_amt;
      OP_SRAV: ALURes = $unsigned($signed(B) >>> w_var_amt);
      OP_LUI:  ALURes = {B[15:0], 16'h0000};
      OP_BEQ:  ALUCond = (A == B);
      OP_BNE:  ALUCond = (A != B);
      OP_BGEZ: ALUCond = ~w_a_neg;
      OP_BGTZ: ALUCond = ~w_a_neg & ~w_a_zero;
      OP_BLEZ: ALUCond = w_a_neg | w_a_zero;
      OP_BLTZ: ALUCond = w_a_neg;
      default: begin
        ALURes  = 32'd0;
        ALUCond = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so HI and LO update together from pre-edge values.
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (SpcRegWriteEn) begin
      case (w_op)
        OP_MULT: begin
          r_hi <= w_mul_s[63:32];
          r_lo <= w_mul_s[31:0];
        end
        OP_MULTU: begin
          r_hi <= w_mul_u[63:32];
          r_lo <= w_mul_u[31:0];
        end
`ifdef MIPS_ALU_DIV_EN
        // A zero divisor leaves HI/LO untouched rather than writing garbage.
        OP_DIV: begin
          if (B != 32'd0) begin
            r_hi <= w_rem_s;
            r_lo <= w_quo_s;
          end
        end
        OP_DIVU: begin
          if (B != 32'd0) begin
            r_hi <= w_rem_u;
            r_lo <= w_quo_u;
          end
        end
`endif
        OP_MTHI: r_hi <= Hi_in;
        OP_MTLO: r_lo <= Lo_in;
        default: ;
      endcase
    end
  end

  assign ALUHi = r_hi;
  assign ALULo = r_lo;

endmodule

// File: tb/tb_mips_alu.sv
// Directed self-checking bench for mips_alu; expected HI/LO follow MIPS_ALU_DIV_EN.
module tb_mips_alu;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ALUOp;
  logic [4:0]  shamt;
  logic [31:0] Hi_in;
  logic [31:0] Lo_in;
  logic        SpcRegWriteEn;
  logic        ALUCond;
  logic [31:0] ALURes;
  logic [31:0] ALUHi;
  logic [31:0] ALULo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mips_alu dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUOp(ALUOp), .shamt(shamt),
    .Hi_in(Hi_in), .Lo_in(Lo_in), .SpcRegWriteEn(SpcRegWriteEn),
    .ALUCond(ALUCond), .ALURes(ALURes), .ALUHi(ALUHi), .ALULo(ALULo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic comb(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh);
    ALUOp = op; A = a; B = b; shamt = sh;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_hilo(input string tag);
    check({tag, "_hi"}, ALUHi, exp_hi);
    check({tag, "_lo"}, ALULo, exp_lo);
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; ALUOp = 5'd0; shamt = '0;
    Hi_in = '0; Lo_in = '0; SpcRegWriteEn = 1'b0;
    #2;
    tick();
    rst = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    check_hilo("reset");

    // Combinational result ops
    comb(5'd0,  32'h7FFF_FFFF, 32'h1, 5'd0);  check("add_ovf",  ALURes, 32'h8000_0000);
    check("add_cond", {31'd0, ALUCond}, 32'd0);
    comb(5'd1,  32'h0, 32'h1, 5'd0);          check("sub_wrap", ALURes, 32'hFFFF_FFFF);
    comb(5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); check("and", ALURes, 32'hF000_F000);
    comb(5'd3,  32'hF0F0_F0F0, 32'h0F00_0F00, 5'd0); check("or",  ALURes, 32'hFFF0_FFF0);
    comb(5'd4,  32'hFFFF_0000, 32'hF0F0_F0F0, 5'd0); check("xor", ALURes, 32'h0F0F_F0F0);
    comb(5'd5,  32'hFFFF_0000, 32'h0000_00FF, 5'd0); check("nor", ALURes, 32'h0000_FF00);
    comb(5'd6,  32'hFFFF_FFFF, 32'h1, 5'd0);  check("slt",  ALURes, 32'h1);
    comb(5'd7,  32'hFFFF_FFFF, 32'h1, 5'd0);  check("sltu", ALURes, 32'h0);
    comb(5'd8,  32'h0, 32'h0000_0003, 5'd31); check("sll",  ALURes, 32'h8000_0000);
    comb(5'd9,  32'h0, 32'h8000_0000, 5'd4);  check("srl",  ALURes, 32'h0800_0000);
    comb(5'd10, 32'h0, 32'h8000_0000, 5'd4);  check("sra",  ALURes, 32'hF800_0000);
    comb(5'd11, 32'd33, 32'h1, 5'd0);         check("sllv", ALURes, 32'h2);
    comb(5'd12, 32'd36, 32'hF0, 5'd0);        check("srlv", ALURes, 32'h0F);
    comb(5'd13, 32'd8, 32'h8000_0000, 5'd0);  check("srav", ALURes, 32'hFF80_0000);
    comb(5'd14, 32'h0, 32'h1234, 5'd0);       check("lui",  ALURes, 32'h1234_0000);

    // HI/LO multiply
    SpcRegWriteEn = 1'b1;
    comb(5'd15, 32'hFFFF_FFFE, 32'd3, 5'd0);  check("mult_res", ALURes, 32'd0);
    tick();
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA; check_hilo("mult");
    comb(5'd16, 32'hFFFF_FFFE, 32'd3, 5'd0);
    tick();
    exp_hi = 32'h0000_0002; exp_lo = 32'hFFFF_FFFA; check_hilo("multu");

    // Divide (behaviour depends on build option)
    comb(5'd17, 32'hFFFF_FFF9, 32'd2, 5'd0);  check("div_res", ALURes, 32'd0);
    check("div_cond", {31'd0, ALUCond}, 32'd0);
    tick();
`ifdef MIPS_ALU_DIV_EN
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
`endif
    check_hilo("div_neg");
    comb(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    tick();
`ifdef MIPS_ALU_DIV_EN
    exp_hi = 32'h0; exp_lo = 32'h8000_0000;
`endif
    check_hilo("div_ovf");
    comb(5'd18, 32'd100, 32'd7, 5'd0);
    tick();
`ifdef MIPS_ALU_DIV_EN
    exp_hi = 32'd2; exp_lo = 32'd14;
`endif
    check_hilo("divu");
    comb(5'd18, 32'd7, 32'd0, 5'd0);
    tick();
    check_hilo("divu_by0");

    // Move-to and write-enable interactions
    Hi_in = 32'hDEAD_BEEF; Lo_in = 32'h1234_5678;
    comb(5'd19, 32'h0, 32'h0, 5'd0);
    tick();
    exp_hi = 32'hDEAD_BEEF; check_hilo("mthi");
    comb(5'd20, 32'h0, 32'h0, 5'd0);
    tick();
    exp_lo = 32'h1234_5678; check_hilo("mtlo");
    comb(5'd0, 32'd5, 32'd6, 5'd0);
    tick();
    check_hilo("en_nonspc");
    comb(5'd31, 32'd5, 32'd6, 5'd0);
    tick();
    check_hilo("en_reserved");
    Hi_in = 32'hAAAA_AAAA;
    comb(5'd19, 32'h0, 32'h0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0; check_hilo("rst_prio");
    SpcRegWriteEn = 1'b0;
    comb(5'd15, 32'hFFFF_FFFE, 32'd3, 5'd0);
    tick();
    check_hilo("mult_noen");

    // Branch conditions
    comb(5'd21, 32'd5, 32'd5, 5'd0);  check("beq_t", {31'd0, ALUCond}, 32'd1);
    check("beq_res", ALURes, 32'd0);
    comb(5'd21, 32'd5, 32'd6, 5'd0);  check("beq_f", {31'd0, ALUCond}, 32'd0);
    comb(5'd22, 32'd5, 32'd5, 5'd0);  check("bne_f", {31'd0, ALUCond}, 32'd0);
    comb(5'd22, 32'd5, 32'd6, 5'd0);  check("bne_t", {31'd0, ALUCond}, 32'd1);
    comb(5'd23, 32'd0, 32'd0, 5'd0);  check("bgez_0", {31'd0, ALUCond}, 32'd1);
    comb(5'd23, 32'hFFFF_FFFF, 32'd0, 5'd0); check("bgez_n", {31'd0, ALUCond}, 32'd0);
    comb(5'd24, 32'd0, 32'd0, 5'd0);  check("bgtz_0", {31'd0, ALUCond}, 32'd0);
    comb(5'd24, 32'd1, 32'd0, 5'd0);  check("bgtz_p", {31'd0, ALUCond}, 32'd1);
    comb(5'd25, 32'd0, 32'd0, 5'd0);  check("blez_0", {31'd0, ALUCond}, 32'd1);
    comb(5'd25, 32'h7FFF_FFFF, 32'd0, 5'd0); check("blez_p", {31'd0, ALUCond}, 32'd0);
    comb(5'd26, 32'h8000_0000, 32'd0, 5'd0); check("bltz_n", {31'd0, ALUCond}, 32'd1);
    comb(5'd26, 32'd0, 32'd0, 5'd0);  check("bltz_0", {31'd0, ALUCond}, 32'd0);

    // Reserved op
    comb(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    check("rsvd_res", ALURes, 32'd0);
    check("rsvd_cond", {31'd0, ALUCond}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
